encoder8_to_3_serial: RTL and testbench

- Sequential priority encoder, the inverse of the team's 3-to-8 decoder.
- Accepts a 2**width-bit request vector over a valid/ready handshake and emits the binary index of every set bit, lowest first, one index per output handshake.
- Used wherever one-hot or multi-hot flag vectors are turned back into binary indices, such as interrupt flags, grant vectors and decoder outputs in loopback checks.

---
 rtl/encoder8_to_3_serial_pkg.sv | 16 +
 rtl/encoder8_to_3_serial_lsb_priority_enc.sv | 24 ++
 rtl/encoder8_to_3_serial.sv | 80 ++++++++
 tb/tb_encoder8_to_3_serial.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder8_to_3_serial_pkg.sv
// Shared types and helpers for the serial priority encoder.
package enc_pkg;

  localparam int unsigned MAX_VEC_W = 256;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // True when exactly one bit of the (zero-extended) vector is set.
  function automatic logic onehot_count_is_one(input logic [MAX_VEC_W-1:0] vec);
    return (vec != '0) && ((vec & (vec - MAX_VEC_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/encoder8_to_3_serial_lsb_priority_enc.sv
// Combinational find-first-set: index of the lowest set bit of a 2**width vector.
module lsb_priority_enc #(
  parameter int unsigned width = 3
) (
  input  logic [(2**width)-1:0] vec_i,
  output logic [width-1:0]      idx_o,
  output logic                  found_o
);

  localparam int unsigned VEC_W = 2**width;

  // Scan downward so the lowest set bit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = int'(VEC_W) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = width'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder8_to_3_serial.sv
// Serial priority encoder: accepts a request vector, emits the index of every set bit, lowest first.
module encoder8_to_3_serial
  import enc_pkg::*;
#(
  parameter int unsigned width = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [(2**width)-1:0] in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [width-1:0]      out,
  output logic                  out_last,
  output logic                  err_zero
);

  localparam int unsigned VEC_W = 2**width;

  state_t            state_q;
  logic [VEC_W-1:0]  pending_q;
  logic              err_zero_q;
  logic [width-1:0]  lsb_idx;
  logic              lsb_found;
  logic              last_beat;

  lsb_priority_enc #(
    .width (width)
  ) u_lsb_enc (
    .vec_i   (pending_q),
    .idx_o   (lsb_idx),
    .found_o (lsb_found)
  );

  assign last_beat = onehot_count_is_one(MAX_VEC_W'(pending_q));

  // Single-process FSM: state, pending bits and the zero-vector flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      err_zero_q <= 1'b0;
    end else begin
      err_zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (in != '0) begin
              pending_q <= in;
              state_q   <= SEND;
            end else begin
              err_zero_q <= 1'b1;
            end
          end
        end
        SEND: begin
          if (out_ready) begin
            pending_q <= pending_q & ~(VEC_W'(1) << lsb_idx);
            if (last_beat) begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          pending_q <= '0;
        end
      endcase
    end
  end

  // Outputs decode only registered state, so no input reaches an output combinationally.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == SEND) && lsb_found;
  assign out       = lsb_idx;
  assign out_last  = (state_q == SEND) && last_beat;
  assign err_zero  = err_zero_q;

endmodule

// File: tb/tb_encoder8_to_3_serial.sv
// Scoreboard bench for encoder8_to_3_serial with width=3.
module tb_encoder8_to_3_serial;

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
  } beat_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       err_zero;

  beat_t exp_q[$];
  int    checks;
  int    errors;

  encoder8_to_3_serial #(.width(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_idx),
    .out_last  (out_last),
    .err_zero  (err_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] decoder3_to_8(input logic [2:0] idx);
    logic [7:0] one;
    one = 8'd1;
    return one << idx;
  endfunction

  // Expected beats: every set bit, ascending, last flag on the highest one.
  task automatic push_expected(input logic [7:0] v);
    int    hi;
    beat_t b;
    hi = -1;
    for (int i = 0; i < 8; i++) if (v[i]) hi = i;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        b.idx  = 3'(i);
        b.last = (i == hi);
        exp_q.push_back(b);
      end
    end
  endtask

  // Present one vector for a single cycle; returns positioned at the negedge after acceptance.
  task automatic accept(input logic [7:0] v);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: in_ready=%b want 1", in_ready);
    end
    in_valid = 1'b1;
    in_vec   = v;
    push_expected(v);
    @(negedge clk);
    in_valid = 1'b0;
    in_vec   = 8'($urandom_range(0, 255));
    checks++;
    if (v != 8'h00) begin
      if (out_valid !== 1'b1 || err_zero !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL latency: out_valid=%b err_zero=%b in_ready=%b want 1 0 0",
                 out_valid, err_zero, in_ready);
      end
    end else begin
      if (out_valid !== 1'b0 || err_zero !== 1'b1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL zero_accept: out_valid=%b err_zero=%b in_ready=%b want 0 1 1",
                 out_valid, err_zero, in_ready);
      end
    end
  endtask

  // Consume beats with a ready pattern (0: always, 1: 1,0,0 repeating, 2: random).
  task automatic drain(input int mode, input logic [7:0] v);
    int         cyc;
    int         nb;
    int         prev;
    bit         stalled;
    beat_t      held;
    beat_t      b;
    logic [7:0] acc;
    cyc = 0; nb = 0; prev = -1; stalled = 1'b0; acc = 8'h00; held = '0;
    while (exp_q.size() != 0 && cyc < 200) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 3) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_idx !== held.idx || out_last !== held.last) begin
          errors++;
          $display("FAIL hold: valid=%b out=%0d last=%b want 1 %0d %b",
                   out_valid, out_idx, out_last, held.idx, held.last);
        end
      end
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL send_state: out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
      end
      if (out_valid === 1'b1 && out_ready) begin
        b = exp_q.pop_front();
        checks++;
        if (out_idx !== b.idx || out_last !== b.last) begin
          errors++;
          $display("FAIL beat: out=%0d last=%b want %0d %b", out_idx, out_last, b.idx, b.last);
        end
        checks++;
        if (int'(out_idx) <= prev) begin
          errors++;
          $display("FAIL order: out=%0d previous=%0d want increasing", out_idx, prev);
        end
        acc     = acc | decoder3_to_8(out_idx);
        prev    = int'(out_idx);
        nb++;
        stalled = 1'b0;
      end else begin
        stalled   = 1'b1;
        held.idx  = out_idx;
        held.last = out_last;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d beats outstanding want 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bubble: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    if (v != 8'h00) begin
      checks++;
      if (acc !== v) begin
        errors++;
        $display("FAIL reconstruct: got %h want %h", acc, v);
      end
      checks++;
      if (nb != $countones(v)) begin
        errors++;
        $display("FAIL beat_count: got %0d want %0d", nb, $countones(v));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 3'd0 ||
        out_last !== 1'b0 || err_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b out=%0d out_last=%b err_zero=%b want 1 0 0 0 0",
               in_ready, out_valid, out_idx, out_last, err_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_single();
    accept(8'b0000_0001);
    drain(0, 8'b0000_0001);
  endtask

  task automatic test_two_bits();
    accept(8'b1000_0100);
    drain(0, 8'b1000_0100);
  endtask

  task automatic test_backpressure();
    accept(8'hFF);
    drain(1, 8'hFF);
  endtask

  task automatic test_zero();
    accept(8'h00);
    drain(0, 8'h00);
    @(negedge clk);
    checks++;
    if (err_zero !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_pulse: err_zero=%b out_valid=%b in_ready=%b want 0 0 1",
               err_zero, out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_send();
    accept(8'hF0);
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd4 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL mid_first: valid=%b out=%0d last=%b want 1 4 0", out_valid, out_idx, out_last);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd5) begin
      errors++;
      $display("FAIL mid_second: valid=%b out=%0d want 1 5", out_valid, out_idx);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    accept(8'h02);
    drain(0, 8'h02);
  endtask

  task automatic test_random();
    logic [7:0] v;
    for (int n = 0; n < 50; n++) begin
      v = 8'($urandom_range(0, 255));
      accept(v);
      drain(2, v);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_two_bits();
    test_backpressure();
    test_zero();
    test_reset_mid_send();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
